// File: rtl/rle_run_expander.sv
// rle_run_expander: expands (value, count) run pairs from a small FIFO into a one-sample-per-cycle stream
module rle_run_expander #(
  parameter int DATA_W     = 9,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_run_end,
  output logic              zero_cnt,
  output logic [15:0]       sample_total
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, EXPAND} state_t;
  logic [DATA_W-1:0] val_mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  cnt_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       occ_q;
  state_t            state_q, state_d;
  logic              valid_q, valid_d, end_q, end_d, zero_q, zero_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [15:0]       total_q, total_d;
  logic              push, pop, load, empty, full;
  logic [DATA_W-1:0] head_val;
  logic [CNT_W-1:0]  head_cnt;
  assign empty        = occ_q == '0;
  assign full         = occ_q == (AW+1)'(FIFO_DEPTH);
  assign in_ready     = !rst && !full;
  assign push         = in_valid && in_ready;
  assign head_val     = val_mem_q[rd_q];
  assign head_cnt     = cnt_mem_q[rd_q];
  assign out_valid    = valid_q;
  assign out_sample   = sample_q;
  assign out_run_end  = end_q;
  assign zero_cnt     = zero_q;
  assign sample_total = total_q;
  // Pair storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      val_mem_q[wr_q] <= in_value;
      cnt_mem_q[wr_q] <= in_count;
    end
  end
  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Run expansion: pop a pair, repeat its value count times, chain into the next run without a bubble
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    end_d    = end_q;
    remain_d = remain_q;
    total_d  = total_q;
    zero_d   = 1'b0;
    pop      = 1'b0;
    load     = 1'b0;
    if (state_q == IDLE) begin
      pop    = !empty;
      load   = !empty && head_cnt != '0;
      zero_d = !empty && head_cnt == '0;
    end else if (out_ready) begin
      total_d  = total_q + 16'd1;
      remain_d = remain_q - CNT_W'(1);
      if (remain_q > CNT_W'(1)) begin
        end_d = remain_q == CNT_W'(2);
      end else if (!empty && head_cnt != '0) begin
        pop  = 1'b1;
        load = 1'b1;
      end else begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end
    if (load) begin
      valid_d  = 1'b1;
      sample_d = head_val;
      remain_d = head_cnt;
      end_d    = head_cnt == CNT_W'(1);
      state_d  = EXPAND;
    end
  end
  // Output stage and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      sample_q <= '0;
      end_q    <= 1'b0;
      remain_q <= '0;
      total_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      end_q    <= end_d;
      remain_q <= remain_d;
      total_q  <= total_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_rle_run_expander.sv
// tb_rle_run_expander: directed loopback checks of the run expander against hand-computed streams
module tb_rle_run_expander;
  localparam int DW = 9;
  localparam int CW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_value = '0;
  logic [CW-1:0] in_count = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sample;
  logic          out_run_end;
  logic          zero_cnt;
  logic [15:0]   sample_total;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, n_zero = 0;
  int got_v[$];
  int got_t[$];
  bit got_e[$];

  rle_run_expander #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_count(in_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_sample(out_sample), .out_run_end(out_run_end),
    .zero_cnt(zero_cnt), .sample_total(sample_total)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Record every handshake and zero-count pulse half a cycle away from the active edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_v.push_back(int'($signed(out_sample)));
      got_e.push_back(out_run_end);
      got_t.push_back(cyc);
    end
    if (!rst && zero_cnt) n_zero++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    got_v.delete();
    got_e.delete();
    got_t.delete();
    n_zero = 0;
  endtask

  task automatic push(input int v, input int c);
    in_valid = 1'b1;
    in_value = DW'(v);
    in_count = CW'(c);
    for (int i = 0; i < 2000; i++) begin
      if (in_ready) begin
        tick;
        acc_cyc = cyc;
        in_valid = 1'b0;
        return;
      end
      tick;
    end
    check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < 70000 && got_v.size() < n; i++) tick;
    check("wait_samples", got_v.size(), n);
  endtask

  initial begin
    int bv, be;
    tick;
    reset_dut;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_sample", int'(out_sample), 0);
    check("rst_end", out_run_end, 0);
    check("rst_zero", zero_cnt, 0);
    check("rst_total", sample_total, 0);

    // single run
    out_ready = 1'b1;
    push(-5, 3);
    wait_n(3);
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      check("single_val", got_v[i], -5);
      check("single_end", got_e[i], i == 2);
    end
    check("single_latency", got_t[0] - acc_cyc, 1);
    check("single_gapless", got_t[2] - got_t[0], 2);
    check("single_total", sample_total, 3);
    check("single_idle", out_valid, 0);

    // back-to-back runs
    reset_dut;
    push(100, 2);
    push(-256, 1);
    push(255, 4);
    wait_n(7);
    tick;
    begin
      int ev[7] = '{100, 100, -256, 255, 255, 255, 255};
      bit ee[7] = '{0, 1, 1, 0, 0, 0, 1};
      for (int i = 0; i < 7; i++) begin
        check("b2b_val", got_v[i], ev[i]);
        check("b2b_end", got_e[i], ee[i]);
      end
    end
    check("b2b_gapless", got_t[6] - got_t[0], 6);
    check("b2b_total", sample_total, 7);

    // backpressure fills the FIFO plus the output stage
    reset_dut;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(10 + i, 2);
    check("full_in_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    check("full_sample", int'($signed(out_sample)), 10);
    tick;
    tick;
    tick;
    check("hold_sample", int'($signed(out_sample)), 10);
    check("hold_end", out_run_end, 0);
    check("hold_count", got_v.size(), 0);
    check("hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    wait_n(10);
    tick;
    for (int i = 0; i < 10; i++) begin
      check("drain_val", got_v[i], 10 + i / 2);
      check("drain_end", got_e[i], i % 2);
    end
    check("drain_total", sample_total, 10);

    // zero-count pair is discarded
    reset_dut;
    push(7, 0);
    push(8, 1);
    wait_n(1);
    repeat (4) tick;
    check("zero_pulses", n_zero, 1);
    check("zero_count", got_v.size(), 1);
    check("zero_val", got_v[0], 8);
    check("zero_end", got_e[0], 1);

    // maximum runs and sample_total wrap
    reset_dut;
    for (int i = 0; i < 257; i++) push(-1, 255);
    wait_n(65535);
    tick;
    tick;
    bv = 0;
    be = 0;
    for (int i = 0; i < 65535; i++) begin
      if (got_v[i] != -1) bv++;
      if (got_e[i] != (i % 255 == 254)) be++;
    end
    check("wrap_vals", bv, 0);
    check("wrap_ends", be, 0);
    check("wrap_total_max", sample_total, 65535);
    push(-1, 1);
    wait_n(65536);
    tick;
    tick;
    check("wrap_total_zero", sample_total, 0);
    check("wrap_last_end", got_e[65535], 1);

    // reset in the middle of a run
    reset_dut;
    push(3, 200);
    push(3, 5);
    wait_n(10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_total", sample_total, 0);
    check("midrst_ready", in_ready, 1);
    repeat (20) tick;
    check("midrst_no_more", got_v.size(), 10);
    check("midrst_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
